bcd_scan_display: RTL and testbench
===================================

# bcd_scan_display

Time-multiplexed seven-segment driver that sits downstream of the cascaded mod-10 counter stages. It takes a packed vector of BCD digits, snapshots it once per scan frame so the display never tears, and drives one digit at a time. Each digit has its own common anode, and all drives are active-low. The block adds decoding, invalid-code indication and optional leading-zero blanking.

## Interface
- DIGITS, 4: number of BCD digits and anodes; legal range 1–8.
- REFRESH_DIV, 50000: clock cycles each digit stays lit; minimum 2.
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- bcd_in  input  4*DIGITS  packed digits; bits [3:0] are digit 0 (least significant, rightmost).
- dp_in  input  DIGITS  decimal-point request per digit, 1 = lit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  output  1  decimal point, active-low, registered.
- an  output  DIGITS  anode enables, active-low, one-hot-low or all-high, registered.
- frame_tick  output  1  one-cycle pulse when a new frame starts showing digit 0.

## Operation
- Prescaler `pcnt` counts 0 .. REFRESH_DIV-1 and then wraps. Its width is clog2(REFRESH_DIV). The terminal count is `pcnt == REFRESH_DIV-1`.
- Scan index `idx` counts 0 .. DIGITS-1 and advances only on the terminal count. It wraps DIGITS-1 → 0.
- Frame wrap is the terminal count while `idx == DIGITS-1`. On frame wrap, `shadow <= bcd_in` and `dp_shadow <= dp_in`.
- Output registers load only on the terminal count, using the new idx:
  - `an` is all ones except bit new-idx, which is 0.
  - `seg` is the decode of digit new-idx.
  - `dp` is `~dp[new-idx]`.
  - On the frame-wrap cycle the digit data is taken directly from `bcd_in`/`dp_in` (the values being captured), not from the stale shadow.
- Decode values (active-low):
  - 0 = 7'b1000000
  - 1 = 7'b1111001
  - 2 = 7'b0100100
  - 3 = 7'b0110000
  - 4 = 7'b0011001
  - 5 = 7'b0010010
  - 6 = 7'b0000010
  - 7 = 7'b1111000
  - 8 = 7'b0000000
  - 9 = 7'b0010000
  - blank = 7'b1111111
- Codes 10–15 are invalid and display a dash (g only), 7'b0111111.
- `frame_tick` is a registered pulse, high for exactly the one cycle after each frame wrap, coincident with `an[0]` first going low.
- Reset state:
  - `pcnt = 0`
  - `idx = DIGITS-1`, so the first terminal count wraps and captures.
  - `shadow = 0`, `dp_shadow = 0`
  - `seg = 7'b1111111`, `dp = 1`, `an` all ones, `frame_tick = 0`

## Timing
- After rst deasserts, all anodes stay off for REFRESH_DIV cycles.
- On cycle REFRESH_DIV after release, the wrap edge occurs. On the following cycle, `an[0]` is low and `frame_tick` is high.
- Each digit is lit for exactly REFRESH_DIV cycles. The full frame period is DIGITS*REFRESH_DIV cycles.
- `bcd_in` changes between frame wraps are not visible until the next wrap. A change on the wrap cycle itself is captured.
- Latency from the sampled `bcd_in` to the digit-0 segment output is 1 cycle. Digit k appears k*REFRESH_DIV cycles later from the same snapshot.
- Reset asserted mid-frame forces all outputs to their reset values immediately, without waiting for clk. The scan restarts from the post-reset sequence.
- With DIGITS = 1, every terminal count is a frame wrap, and `frame_tick` pulses every REFRESH_DIV cycles.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit i ≥ 1 shows blank when its snapshot value and all higher digits' values are 0.
  - Digit 0 is never blanked.
  - Invalid codes count as non-zero.
  - `dp` still follows `dp_in` on blanked digits.
- LEADING_ZERO_BLANK_EN undefined: every digit is always decoded, and zeros show as 0.

## Test plan
- Reset and first frame (DIGITS=4, REFRESH_DIV=4, bcd_in=16'h1234):
  - During rst, outputs are seg=7'h7F, an=4'hF, dp=1.
  - After release, anodes stay off for 4 cycles.
  - Then an=4'b1110 with seg=7'b0011001 (4), and frame_tick high for 1 cycle.
  - Then 3, 2, 1 follow, each held for 4 cycles.
- Snapshot hold: change bcd_in from 16'h1234 to 16'h5678 while digit 1 is lit -> digits 2 and 3 still show 2 and 1; the next frame shows 8, 7, 6, 5.
- Invalid code: bcd_in=16'h00A0 -> digit 1 shows 7'b0111111; digits 0, 2 and 3 show 0, or 2/3 are blank when the macro is defined.
- Blanking (macro defined): bcd_in=16'h0000 -> only digit 0 shows 0. bcd_in=16'h0105 -> digit 3 is blank, digit 2 shows 1, digit 1 shows 0.
- Decimal point: dp_in=4'b0100 -> dp=0 only while an=4'b1011.
- Async reset mid-frame: assert rst between clk edges while digit 2 is lit -> an=4'hF immediately; after release the sequence matches the reset-and-first-frame case.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Time-multiplexed, active-low seven-segment driver with a once-per-frame snapshot of the BCD digits.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is never blanked).
module bcd_scan_display #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_tick
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);

   logic [PW-1:0]          pcnt;
   logic [IW-1:0]          idx, nidx;
   logic [4*DIGITS-1:0]    shadow, cur_bcd;
   logic [DIGITS-1:0]      dp_shadow, cur_dp, blank;
   logic [3:0]             digit;
   logic                   tc, wrap;
   logic [6:0]             seg_nxt;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b0111111;
      endcase
   endfunction

   assign tc   = (pcnt == PLAST);
   assign wrap = tc && (idx == ILAST);
   assign nidx = wrap ? '0 : IW'(idx + 1'b1);

   // On the wrap cycle the shadow is stale; show the value being captured.
   assign cur_bcd = wrap ? bcd_in : shadow;
   assign cur_dp  = wrap ? dp_in  : dp_shadow;
   assign digit   = cur_bcd[4*nidx +: 4];

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      logic nz;
      nz    = 1'b0;
      blank = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         nz       = nz | (|cur_bcd[4*i +: 4]);
         blank[i] = ~nz;
      end
   end
`else
   assign blank = '0;
`endif

   assign seg_nxt = blank[nidx] ? 7'b1111111 : decode(digit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt       <= '0;
         idx        <= ILAST;
         shadow     <= '0;
         dp_shadow  <= '0;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
         an         <= '1;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= wrap;
         pcnt       <= tc ? '0 : PW'(pcnt + 1'b1);
         if (tc) begin
            idx <= nidx;
            seg <= seg_nxt;
            dp  <= ~cur_dp[nidx];
            an  <= ~(DIGITS'(1) << nidx);
         end
         if (wrap) begin
            shadow    <= bcd_in;
            dp_shadow <= dp_in;
         end
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with DIGITS=4, REFRESH_DIV=4; outputs sampled on the falling edge.
module tb_bcd_scan_display;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000, SD = 7'b0111111, SB = 7'b1111111;
   localparam logic [3:0] AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bcd_in = 16'h1234;
   logic [3:0]  dp_in = 4'b0000;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;
   int          pass = 0, total = 0;

   bcd_scan_display #(.DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in),
      .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse reset across one falling edge; returns at the release edge (cycle 0).
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Walks one frame starting 4 cycles after release/wrap, checking digit k at its first cycle.
   task automatic check_frame(input string nm, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] ex [4];
      ex = '{e0, e1, e2, e3};
      for (int k = 0; k < 4; k++) begin
         if (k != 0) cyc(4);
         total++;
         if (an !== AN[k] || seg !== ex[k])
            $display("FAIL %s digit%0d: an=%b seg=%b, want an=%b seg=%b", nm, k, an, seg, AN[k], ex[k]);
         else pass++;
      end
   endtask

   task automatic test_reset();
      bcd_in = 16'h1234;
      dp_in  = 4'b0000;
      cyc(1);
      total++;
      if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1 || frame_tick !== 1'b0)
         $display("FAIL reset_state: seg=%h an=%h dp=%b tick=%b, want 7f f 1 0", seg, an, dp, frame_tick);
      else pass++;
   endtask

   task automatic test_first_frame();
      do_reset();
      for (int c = 1; c <= 3; c++) begin
         cyc(1);
         total++;
         if (an !== 4'hF || frame_tick !== 1'b0)
            $display("FAIL anodes_off cyc%0d: an=%h tick=%b, want f 0", c, an, frame_tick);
         else pass++;
      end
      cyc(1);
      total++;
      if (frame_tick !== 1'b1) $display("FAIL first_tick: tick=%b, want 1", frame_tick);
      else pass++;
      check_frame("first_frame", S4, S3, S2, S1);
      // Last cycle of digit 3 still holds; next cycle wraps back to digit 0.
      cyc(3);
      total++;
      if (an !== 4'b0111 || seg !== S1 || frame_tick !== 1'b0)
         $display("FAIL hold_digit3: an=%b seg=%b tick=%b, want 0111 %b 0", an, seg, frame_tick, S1);
      else pass++;
      cyc(1);
      total++;
      if (an !== 4'b1110 || seg !== S4 || frame_tick !== 1'b1)
         $display("FAIL second_wrap: an=%b seg=%b tick=%b, want 1110 %b 1", an, seg, frame_tick, S4);
      else pass++;
      cyc(1);
      total++;
      if (frame_tick !== 1'b0) $display("FAIL tick_width: tick=%b, want 0", frame_tick);
      else pass++;
   endtask

   task automatic test_snapshot();
      bcd_in = 16'h1234;
      do_reset();
      cyc(8);
      bcd_in = 16'h5678;
      total++;
      if (seg !== S3) $display("FAIL snap_d1: seg=%b, want %b", seg, S3);
      else pass++;
      cyc(4);
      total++;
      if (seg !== S2) $display("FAIL snap_d2: seg=%b, want %b", seg, S2);
      else pass++;
      cyc(4);
      total++;
      if (seg !== S1) $display("FAIL snap_d3: seg=%b, want %b", seg, S1);
      else pass++;
      cyc(4);
      check_frame("snap_next", S8, S7, S6, S5);
   endtask

   task automatic test_invalid();
      bcd_in = 16'h00A0;
      do_reset();
      cyc(4);
`ifdef LEADING_ZERO_BLANK_EN
      check_frame("invalid", S0, SD, SB, SB);
`else
      check_frame("invalid", S0, SD, S0, S0);
`endif
   endtask

   task automatic test_blank();
      bcd_in = 16'h0105;
      do_reset();
      cyc(4);
`ifdef LEADING_ZERO_BLANK_EN
      check_frame("lz_0105", S5, S0, S1, SB);
`else
      check_frame("lz_0105", S5, S0, S1, S0);
`endif
      bcd_in = 16'h0000;
      do_reset();
      cyc(4);
`ifdef LEADING_ZERO_BLANK_EN
      check_frame("lz_0000", S0, SB, SB, SB);
`else
      check_frame("lz_0000", S0, S0, S0, S0);
`endif
   endtask

   task automatic test_dp();
      logic ed [4];
      ed = '{1'b1, 1'b1, 1'b0, 1'b1};
      bcd_in = 16'h1234;
      dp_in  = 4'b0100;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cyc(4);
         total++;
         if (dp !== ed[k] || an !== AN[k])
            $display("FAIL dp_digit%0d: dp=%b an=%b, want dp=%b an=%b", k, dp, an, ed[k], AN[k]);
         else pass++;
      end
      dp_in = 4'b0000;
   endtask

   task automatic test_async_reset();
      bcd_in = 16'h1234;
      do_reset();
      cyc(12);
      #2 rst = 1'b1;
      #1;
      total++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0)
         $display("FAIL async_reset: an=%h seg=%h dp=%b tick=%b, want f 7f 1 0", an, seg, dp, frame_tick);
      else pass++;
      @(negedge clk);
      rst = 1'b0;
      cyc(3);
      total++;
      if (an !== 4'hF) $display("FAIL async_restart_off: an=%h, want f", an);
      else pass++;
      cyc(1);
      total++;
      if (frame_tick !== 1'b1) $display("FAIL async_restart_tick: tick=%b, want 1", frame_tick);
      else pass++;
      check_frame("async_restart", S4, S3, S2, S1);
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_snapshot();
      test_invalid();
      test_blank();
      test_dp();
      test_async_reset();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
